// File: rtl/ising_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ising_ctrl_pkg
// Shared definitions for the Ising array run sequencer: FSM state encoding,
// config register byte offsets and CTRL register bit positions.
// No ports (package).
// ---------------------------------------------------------------------------
package ising_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RESET,
      RUN,
      SETTLE,
      CAPTURE,
      DONE
   } state_t;

   localparam logic [31:0] REG_CTRL       = 32'h0000_0000;
   localparam logic [31:0] REG_RUN_CYCLES = 32'h0000_0004;
   localparam logic [31:0] REG_NUM_RUNS   = 32'h0000_0008;

   localparam int CTRL_START   = 0;
   localparam int CTRL_ABORT   = 1;
   localparam int CTRL_CLR_ERR = 2;

endpackage

// File: rtl/ising_spin_sync.sv
// ---------------------------------------------------------------------------
// ising_spin_sync
// Multi-flop synchroniser bringing the free-running oscillator spin outputs
// into the clk_main_a0 domain. Each bit is synchronised independently; the
// spins are frozen (core_run low) long enough before sampling that bit-skew
// across the bus does not matter.
// Ports:
//   clk_main_a0  in   1  main clock
//   spins_raw    in   N  asynchronous spin outputs from the array
//   spins_sync   out  N  synchronised spins
// ---------------------------------------------------------------------------
module ising_spin_sync #(
   parameter int N           = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk_main_a0,
   input  logic [N-1:0] spins_raw,
   output logic [N-1:0] spins_sync
);

   (* ASYNC_REG = "TRUE" *) logic [N-1:0] sync_chain [SYNC_STAGES];

   always_ff @(posedge clk_main_a0) begin
      sync_chain[0] <= spins_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_chain[i] <= sync_chain[i-1];
      end
   end

   assign spins_sync = sync_chain[SYNC_STAGES-1];

endmodule

// File: rtl/ising_run_sequencer.sv
// ---------------------------------------------------------------------------
// ising_run_sequencer
// Run-control for the coupled-oscillator Ising array. Decodes host config
// writes, forwards weight writes to the array while idle, and sequences each
// anneal: reset -> run -> freeze/settle -> capture, repeated NUM_RUNS times.
// Ports:
//   clk_main_a0   in   1       main clock
//   rst_main_n    in   1       asynchronous active-low reset
//   cfg_wr_valid  in   1       write strobe
//   cfg_wr_addr   in   ADDR_W  write byte address
//   cfg_wr_data   in   32      write data
//   cfg_wr_ack    out  1       ack, one cycle after every write strobe
//   core_we       out  1       weight write strobe to array
//   core_waddr    out  ADDR_W  weight address (relative to WEIGHT_BASE)
//   core_wdata    out  32      weight data
//   core_rstn     out  1       array reset, active low
//   core_run      out  1       array oscillation enable
//   core_spins    in   N       raw asynchronous spin outputs
//   snap_spins    out  N       spins captured at end of last run
//   busy          out  1       sequencer not idle
//   done          out  1       sticky job-complete flag
//   err           out  1       sticky rejected-write / start-while-busy flag
//   runs_done     out  16      completed runs in current/last job
// ---------------------------------------------------------------------------
module ising_run_sequencer
   import ising_ctrl_pkg::*;
#(
   parameter int                N           = 64,
   parameter int                ADDR_W      = 32,
   parameter int                RST_CYCLES  = 16,
   parameter int                SYNC_STAGES = 2,
   parameter logic [ADDR_W-1:0] WEIGHT_BASE = 'h100
) (
   input  logic              clk_main_a0,
   input  logic              rst_main_n,
   input  logic              cfg_wr_valid,
   input  logic [ADDR_W-1:0] cfg_wr_addr,
   input  logic [31:0]       cfg_wr_data,
   output logic              cfg_wr_ack,
   output logic              core_we,
   output logic [ADDR_W-1:0] core_waddr,
   output logic [31:0]       core_wdata,
   output logic              core_rstn,
   output logic              core_run,
   input  logic [N-1:0]      core_spins,
   output logic [N-1:0]      snap_spins,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       runs_done
);

   localparam logic [31:0] RST_LOAD    = 32'(RST_CYCLES - 1);
   localparam logic [31:0] SETTLE_LOAD = 32'(SYNC_STAGES);

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Reset: asserts asynchronously, releases on a clock edge.
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) rst_sync <= 2'b00;
      else             rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   logic [N-1:0] spins_sync;

   ising_spin_sync #(
      .N           (N),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_spin_sync (
      .clk_main_a0 (clk_main_a0),
      .spins_raw   (core_spins),
      .spins_sync  (spins_sync)
   );

   state_t      state;
   logic [31:0] cnt;          // shared by RESET / RUN / SETTLE
   logic [31:0] run_cycles;
   logic [15:0] num_runs;
   logic [31:0] job_len;      // effective run length latched at start
   logic [15:0] job_runs;     // effective run count latched at start

   logic wr_ctrl, wr_rc, wr_nr, wr_wgt;

   assign busy    = (state != IDLE);
   assign wr_ctrl = cfg_wr_valid && (cfg_wr_addr == ADDR_W'(REG_CTRL));
   assign wr_rc   = cfg_wr_valid && (cfg_wr_addr == ADDR_W'(REG_RUN_CYCLES));
   assign wr_nr   = cfg_wr_valid && (cfg_wr_addr == ADDR_W'(REG_NUM_RUNS));
   assign wr_wgt  = cfg_wr_valid && (cfg_wr_addr >= WEIGHT_BASE);

   always_ff @(posedge clk_main_a0 or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         run_cycles <= '0;
         num_runs   <= '0;
         job_len    <= '0;
         job_runs   <= '0;
         cfg_wr_ack <= 1'b0;
         core_we    <= 1'b0;
         core_rstn  <= 1'b0;
         core_run   <= 1'b0;
         snap_spins <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         runs_done  <= '0;
      end else begin
         cfg_wr_ack <= cfg_wr_valid;
         core_we    <= 1'b0;

         // clr_err first so that a rejection in the same cycle still wins
         if (wr_ctrl && cfg_wr_data[CTRL_CLR_ERR]) err <= 1'b0;

         if (wr_rc) begin
            if (busy) err <= 1'b1;
            else      run_cycles <= cfg_wr_data;
         end
         if (wr_nr) begin
            if (busy) err <= 1'b1;
            else      num_runs <= cfg_wr_data[15:0];
         end
         if (wr_wgt) begin
            if (busy) err <= 1'b1;
            else      core_we <= 1'b1;
         end

         case (state)
            RESET: begin
               if (cnt == '0) begin
                  state     <= RUN;
                  cnt       <= job_len - 32'd1;
                  core_rstn <= 1'b1;
                  core_run  <= 1'b1;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            RUN: begin
               if (cnt == '0) begin
                  state    <= SETTLE;
                  cnt      <= SETTLE_LOAD;
                  core_run <= 1'b0;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            SETTLE: begin
               if (cnt == '0) state <= CAPTURE;
               else           cnt   <= cnt - 32'd1;
            end
            CAPTURE: begin
               snap_spins <= spins_sync;
               runs_done  <= sat_inc(runs_done);
               if (({1'b0, runs_done} + 17'd1) < {1'b0, job_runs}) begin
                  state     <= RESET;
                  cnt       <= RST_LOAD;
                  core_rstn <= 1'b0;
               end else begin
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: ;
         endcase

         // Host commands override the sequencing above; abort beats start.
         if (wr_ctrl && cfg_wr_data[CTRL_ABORT]) begin
            state     <= IDLE;
            core_run  <= 1'b0;
            core_rstn <= 1'b0;
         end else if (wr_ctrl && cfg_wr_data[CTRL_START]) begin
            if (busy) begin
               err <= 1'b1;
            end else begin
               done      <= 1'b0;
               runs_done <= '0;
               job_len   <= (run_cycles == '0) ? 32'd1 : run_cycles;
               job_runs  <= (num_runs == '0) ? 16'd1 : num_runs;
               cnt       <= RST_LOAD;
               core_rstn <= 1'b0;
               core_run  <= 1'b0;
               state     <= RESET;
            end
         end
      end
   end

   // Weight address/data are payload only; core_we qualifies them.
   always_ff @(posedge clk_main_a0) begin
      if (wr_wgt && !busy) begin
         core_waddr <= cfg_wr_addr - WEIGHT_BASE;
         core_wdata <= cfg_wr_data;
      end
   end

endmodule

// File: tb/tb_ising_run_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ising_run_sequencer
// Directed self-checking bench for ising_run_sequencer (default parameters:
// N=64, RST_CYCLES=16, SYNC_STAGES=2, WEIGHT_BASE=0x100).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ising_run_sequencer;

   logic        clk_main_a0 = 1'b0;
   logic        rst_main_n;
   logic        cfg_wr_valid;
   logic [31:0] cfg_wr_addr;
   logic [31:0] cfg_wr_data;
   logic        cfg_wr_ack;
   logic        core_we;
   logic [31:0] core_waddr;
   logic [31:0] core_wdata;
   logic        core_rstn;
   logic        core_run;
   logic [63:0] core_spins;
   logic [63:0] snap_spins;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] runs_done;

   int checks = 0;
   int errors = 0;

   always #5 clk_main_a0 = ~clk_main_a0;

   ising_run_sequencer dut (
      .clk_main_a0  (clk_main_a0),
      .rst_main_n   (rst_main_n),
      .cfg_wr_valid (cfg_wr_valid),
      .cfg_wr_addr  (cfg_wr_addr),
      .cfg_wr_data  (cfg_wr_data),
      .cfg_wr_ack   (cfg_wr_ack),
      .core_we      (core_we),
      .core_waddr   (core_waddr),
      .core_wdata   (core_wdata),
      .core_rstn    (core_rstn),
      .core_run     (core_run),
      .core_spins   (core_spins),
      .snap_spins   (snap_spins),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .runs_done    (runs_done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // One write; returns on the negedge after the strobe, where ack must be high.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk_main_a0);
      cfg_wr_valid = 1'b1;
      cfg_wr_addr  = a;
      cfg_wr_data  = d;
      @(negedge clk_main_a0);
      cfg_wr_valid = 1'b0;
      chk("wr_ack", 64'(cfg_wr_ack), 64'd1);
   endtask

   // Samples each negedge until the sequencer is idle again.
   task automatic run_job(input int budget, output int rc, output int rs,
                          output int rp, output int de, output int ok);
      logic prev;
      rc = 0; rs = 0; rp = 0; de = 0; ok = 0; prev = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!busy) begin
            ok = 1;
            break;
         end
         if (core_run) rc++;
         if (core_run && !prev) rp++;
         prev = core_run;
         if (!core_rstn) rs++;
         if (done) de++;
         @(negedge clk_main_a0);
      end
   endtask

   // Waits (bounded) until core_run equals lvl; returns 1 if seen.
   task automatic wait_run(input logic lvl, input int budget, output int ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (core_run === lvl) begin
            ok = 1;
            break;
         end
         @(negedge clk_main_a0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc, rs, rp, de, ok;
      rst_main_n   = 1'b0;
      cfg_wr_valid = 1'b0;
      cfg_wr_addr  = '0;
      cfg_wr_data  = '0;
      core_spins   = '0;
      repeat (3) @(negedge clk_main_a0);

      // Reset state
      chk("rst_core_rstn", 64'(core_rstn), 64'd0);
      chk("rst_core_run",  64'(core_run),  64'd0);
      chk("rst_core_we",   64'(core_we),   64'd0);
      chk("rst_ack",       64'(cfg_wr_ack), 64'd0);
      chk("rst_snap",      snap_spins,     64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_done",      64'(done),      64'd0);
      chk("rst_err",       64'(err),       64'd0);
      chk("rst_runs_done", 64'(runs_done), 64'd0);
      rst_main_n = 1'b1;
      repeat (3) @(negedge clk_main_a0);

      // 1) single run of 10 cycles
      core_spins = 64'hA5A5_A5A5_A5A5_A5A5;
      wr(32'h4, 32'd10);
      wr(32'h8, 32'd1);
      wr(32'h0, 32'h1);
      chk("t1_busy_after_start", 64'(busy), 64'd1);
      run_job(300, rc, rs, rp, de, ok);
      chk("t1_finished",  64'(ok), 64'd1);
      chk("t1_run_cyc",   64'(rc), 64'd10);
      chk("t1_rst_cyc",   64'(rs), 64'd16);
      chk("t1_pulses",    64'(rp), 64'd1);
      chk("t1_done",      64'(done), 64'd1);
      chk("t1_snap",      snap_spins, 64'hA5A5_A5A5_A5A5_A5A5);
      chk("t1_runs_done", 64'(runs_done), 64'd1);
      chk("t1_rstn_idle", 64'(core_rstn), 64'd1);

      // 2) three runs
      core_spins = 64'h0123_4567_89AB_CDEF;
      wr(32'h8, 32'd3);
      wr(32'h0, 32'h1);
      chk("t2_done_cleared", 64'(done), 64'd0);
      run_job(500, rc, rs, rp, de, ok);
      chk("t2_finished",  64'(ok), 64'd1);
      chk("t2_run_cyc",   64'(rc), 64'd30);
      chk("t2_rst_cyc",   64'(rs), 64'd48);
      chk("t2_pulses",    64'(rp), 64'd3);
      chk("t2_done_early", 64'(de), 64'd0);
      chk("t2_done",      64'(done), 64'd1);
      chk("t2_runs_done", 64'(runs_done), 64'd3);
      chk("t2_snap",      snap_spins, 64'h0123_4567_89AB_CDEF);

      // 3) weight writes, rejections, err handling
      wr(32'h104, 32'hDEAD_BEEF);
      chk("t3_we",    64'(core_we), 64'd1);
      chk("t3_waddr", 64'(core_waddr), 64'h4);
      chk("t3_wdata", 64'(core_wdata), 64'hDEAD_BEEF);
      @(negedge clk_main_a0);
      chk("t3_we_pulse", 64'(core_we), 64'd0);
      wr(32'h4, 32'd100);
      wr(32'h8, 32'd1);
      wr(32'h0, 32'h1);
      wr(32'h104, 32'h1234_5678);
      chk("t3_we_busy",  64'(core_we), 64'd0);
      chk("t3_err_wgt",  64'(err), 64'd1);
      wr(32'h0, 32'h4);
      chk("t3_err_clr",  64'(err), 64'd0);
      wr(32'h0, 32'h1);
      chk("t3_err_start_busy", 64'(err), 64'd1);
      chk("t3_still_busy",     64'(busy), 64'd1);
      wr(32'h4, 32'd7);
      wr(32'h0, 32'h2);
      chk("t3_abort_idle", 64'(busy), 64'd0);

      // 4) abort at RUN cycle 5 of 100 (RUN_CYCLES=7 write above was dropped)
      core_spins = 64'hFFFF_0000_FFFF_0000;
      wr(32'h0, 32'h1);
      wait_run(1'b1, 40, ok);
      chk("t4_run_seen", 64'(ok), 64'd1);
      repeat (3) @(negedge clk_main_a0);
      wr(32'h0, 32'h2);
      chk("t4_busy",      64'(busy), 64'd0);
      chk("t4_core_run",  64'(core_run), 64'd0);
      chk("t4_core_rstn", 64'(core_rstn), 64'd0);
      chk("t4_done",      64'(done), 64'd0);
      chk("t4_snap",      snap_spins, 64'h0123_4567_89AB_CDEF);
      chk("t4_runs_done", 64'(runs_done), 64'd0);
      chk("t4_err_held",  64'(err), 64'd1);

      // 5) zero counts behave as one; start+abort stays idle
      wr(32'h4, 32'd0);
      wr(32'h8, 32'd0);
      wr(32'h0, 32'h1);
      run_job(200, rc, rs, rp, de, ok);
      chk("t5_finished",  64'(ok), 64'd1);
      chk("t5_run_cyc",   64'(rc), 64'd1);
      chk("t5_pulses",    64'(rp), 64'd1);
      chk("t5_done",      64'(done), 64'd1);
      chk("t5_runs_done", 64'(runs_done), 64'd1);
      chk("t5_snap",      snap_spins, 64'hFFFF_0000_FFFF_0000);
      wr(32'h0, 32'h3);
      chk("t5_sa_busy", 64'(busy), 64'd0);
      chk("t5_sa_done", 64'(done), 64'd1);
      chk("t5_sa_rstn", 64'(core_rstn), 64'd0);
      @(negedge clk_main_a0);
      chk("t5_sa_busy2", 64'(busy), 64'd0);

      // 6) clr_err+start, then async reset mid-SETTLE
      wr(32'h4, 32'd5);
      wr(32'h8, 32'd1);
      wr(32'h0, 32'h5);
      chk("t6_clr_start_err",  64'(err), 64'd0);
      chk("t6_clr_start_busy", 64'(busy), 64'd1);
      wr(32'h104, 32'h0);
      chk("t6_err_set", 64'(err), 64'd1);
      wait_run(1'b1, 40, ok);
      chk("t6_run_seen", 64'(ok), 64'd1);
      wait_run(1'b0, 20, ok);
      chk("t6_settle_seen", 64'(ok), 64'd1);
      #2;
      rst_main_n = 1'b0;
      #1;
      chk("t6_rst_busy",      64'(busy), 64'd0);
      chk("t6_rst_rstn",      64'(core_rstn), 64'd0);
      chk("t6_rst_run",       64'(core_run), 64'd0);
      chk("t6_rst_err",       64'(err), 64'd0);
      chk("t6_rst_snap",      snap_spins, 64'd0);
      chk("t6_rst_runs_done", 64'(runs_done), 64'd0);
      @(negedge clk_main_a0);
      rst_main_n = 1'b1;
      repeat (3) @(negedge clk_main_a0);
      wr(32'h0, 32'h1);
      run_job(200, rc, rs, rp, de, ok);
      chk("t6_finished",  64'(ok), 64'd1);
      chk("t6_run_cyc",   64'(rc), 64'd1);
      chk("t6_runs_done", 64'(runs_done), 64'd1);
      chk("t6_done",      64'(done), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
